// File: rtl/vx_gpr_writeback_arb.sv
// Writer side of the GPR writeback interface: round-robin arbitration of commit ports
// into one registered writeback beat per cycle, keeping multi-beat packets contiguous.
module vx_gpr_writeback_arb #(
  parameter int NUM_INPUTS  = 4,
  parameter int NUM_THREADS = 4,
  parameter int XLEN        = 32,
  parameter int NR_BITS     = 6,
  parameter int WIS_BITS    = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_INPUTS-1:0]               in_valid,
  output logic [NUM_INPUTS-1:0]               in_ready,
  input  logic [NUM_INPUTS-1:0]               in_wb,
  input  logic [NUM_INPUTS*WIS_BITS-1:0]      in_wis,
  input  logic [NUM_INPUTS*NR_BITS-1:0]       in_rd,
  input  logic [NUM_INPUTS*NUM_THREADS-1:0]   in_tmask,
  input  logic [NUM_INPUTS*NUM_THREADS*XLEN-1:0] in_data,
  input  logic [NUM_INPUTS-1:0]               in_sop,
  input  logic [NUM_INPUTS-1:0]               in_eop,
  output logic                                wb_valid,
  output logic [WIS_BITS-1:0]                 wb_wis,
  output logic [NR_BITS-1:0]                  wb_rd,
  output logic [NUM_THREADS-1:0]              wb_tmask,
  output logic [NUM_THREADS*XLEN-1:0]         wb_data,
  output logic                                wb_sop,
  output logic                                wb_eop,
  output logic                                err_sop
);

  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int DW    = NUM_THREADS * XLEN;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       locked_id_q, locked_id_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]       grant_id, cand;
  logic                   grant_valid;
  logic                   err_d;
  logic                   sel_wb, sel_sop, sel_eop;
  logic [WIS_BITS-1:0]    sel_wis;
  logic [NR_BITS-1:0]     sel_rd;
  logic [NUM_THREADS-1:0] sel_tmask;
  logic [DW-1:0]          sel_data;

  // A locked packet owns the port until its eop; otherwise scan circularly from rr_ptr.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    cand        = '0;
    if (state_q == LOCKED) begin
      grant_id    = locked_id_q;
      grant_valid = in_valid[locked_id_q];
    end else begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        cand = IDX_W'((int'(rr_ptr_q) + i) % NUM_INPUTS);
        if (!grant_valid && in_valid[cand]) begin
          grant_valid = 1'b1;
          grant_id    = cand;
        end
      end
    end
    if (reset) grant_valid = 1'b0;
    in_ready = '0;
    in_ready[grant_id] = grant_valid;
  end

  always_comb begin
    sel_wb    = in_wb[grant_id];
    sel_sop   = in_sop[grant_id];
    sel_eop   = in_eop[grant_id];
    sel_wis   = in_wis[grant_id*WIS_BITS +: WIS_BITS];
    sel_rd    = in_rd[grant_id*NR_BITS +: NR_BITS];
    sel_tmask = in_tmask[grant_id*NUM_THREADS +: NUM_THREADS];
    sel_data  = in_data[grant_id*DW +: DW];
  end

  // The sop flag must agree with the lock state of the cycle the beat is accepted in.
  always_comb begin
    state_d     = state_q;
    locked_id_d = locked_id_q;
    rr_ptr_d    = rr_ptr_q;
    err_d       = 1'b0;
    if (grant_valid) begin
      err_d = (state_q == LOCKED) ? sel_sop : !sel_sop;
      if (sel_eop) begin
        state_d  = IDLE;
        rr_ptr_d = (grant_id == IDX_W'(NUM_INPUTS - 1)) ? '0 : grant_id + 1'b1;
      end else begin
        state_d     = LOCKED;
        locked_id_d = grant_id;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      locked_id_q <= '0;
      rr_ptr_q    <= '0;
      wb_valid    <= 1'b0;
      wb_sop      <= 1'b0;
      wb_eop      <= 1'b0;
      err_sop     <= 1'b0;
      wb_wis      <= '0;
      wb_rd       <= '0;
      wb_tmask    <= '0;
      wb_data     <= '0;
    end else begin
      state_q     <= state_d;
      locked_id_q <= locked_id_d;
      rr_ptr_q    <= rr_ptr_d;
      wb_valid    <= grant_valid & sel_wb;
      wb_sop      <= grant_valid & sel_wb & sel_sop;
      wb_eop      <= grant_valid & sel_wb & sel_eop;
      err_sop     <= err_d;
      if (grant_valid && sel_wb) begin
        wb_wis   <= sel_wis;
        wb_rd    <= sel_rd;
        wb_tmask <= sel_tmask;
        wb_data  <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_vx_gpr_writeback_arb.sv
// Bench for vx_gpr_writeback_arb: directed scenarios with literal expectations, then
// randomized packet traffic checked every cycle against a behavioural model.
module tb_vx_gpr_writeback_arb;

  localparam int N = 4;
  localparam int T = 4;
  localparam int X = 32;
  localparam int R = 6;
  localparam int W = 2;
  localparam int D = T * X;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     in_valid, in_ready, in_wb, in_sop, in_eop;
  logic [N*W-1:0]   in_wis;
  logic [N*R-1:0]   in_rd;
  logic [N*T-1:0]   in_tmask;
  logic [N*D-1:0]   in_data;
  logic             wb_valid, wb_sop, wb_eop, err_sop;
  logic [W-1:0]     wb_wis;
  logic [R-1:0]     wb_rd;
  logic [T-1:0]     wb_tmask;
  logic [D-1:0]     wb_data;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  vx_gpr_writeback_arb #(
    .NUM_INPUTS(N), .NUM_THREADS(T), .XLEN(X), .NR_BITS(R), .WIS_BITS(W)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_wb(in_wb), .in_wis(in_wis),
    .in_rd(in_rd), .in_tmask(in_tmask), .in_data(in_data), .in_sop(in_sop),
    .in_eop(in_eop), .wb_valid(wb_valid), .wb_wis(wb_wis), .wb_rd(wb_rd),
    .wb_tmask(wb_tmask), .wb_data(wb_data), .wb_sop(wb_sop), .wb_eop(wb_eop),
    .err_sop(err_sop)
  );

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int p, input logic v, input logic wb, input logic [W-1:0] wis,
                               input logic [R-1:0] rd, input logic [T-1:0] tm,
                               input logic [D-1:0] data, input logic sop, input logic eop);
    in_valid[p +: 1] = v;
    in_wb[p +: 1]    = wb;
    in_sop[p +: 1]   = sop;
    in_eop[p +: 1]   = eop;
    in_wis[p*W +: W]   = wis;
    in_rd[p*R +: R]    = rd;
    in_tmask[p*T +: T] = tm;
    in_data[p*D +: D]  = data;
  endtask

  task automatic clearInputs();
    in_valid = '0; in_wb = '0; in_sop = '0; in_eop = '0;
    in_wis = '0; in_rd = '0; in_tmask = '0; in_data = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: lock owner, round-robin start point and the beat expected next cycle.
  bit            armed = 1'b0;
  bit            m_lock = 1'b0;
  int            m_id = 0;
  int            m_rr = 0;
  int            g;
  logic [N-1:0]  exp_ready;
  logic          exp_valid = 1'b0, exp_sop = 1'b0, exp_eop = 1'b0, exp_err = 1'b0;
  logic [W-1:0]  exp_wis;
  logic [R-1:0]  exp_rd;
  logic [T-1:0]  exp_tmask;
  logic [D-1:0]  exp_data;

  always @(negedge clk) begin
    if (armed) begin
      checkOutput("wb_valid", 128'(wb_valid), 128'(exp_valid));
      checkOutput("wb_sop", 128'(wb_sop), 128'(exp_sop));
      checkOutput("wb_eop", 128'(wb_eop), 128'(exp_eop));
      checkOutput("err_sop", 128'(err_sop), 128'(exp_err));
      if (exp_valid) begin
        checkOutput("wb_wis", 128'(wb_wis), 128'(exp_wis));
        checkOutput("wb_rd", 128'(wb_rd), 128'(exp_rd));
        checkOutput("wb_tmask", 128'(wb_tmask), 128'(exp_tmask));
        checkOutput("wb_data", 128'(wb_data), 128'(exp_data));
      end
    end
    g = -1;
    if (!reset) begin
      if (m_lock) begin
        if (in_valid[m_id +: 1] == 1'b1) g = m_id;
      end else begin
        for (int k = 0; k < N; k++)
          if (g < 0 && in_valid[((m_rr + k) % N) +: 1] == 1'b1) g = (m_rr + k) % N;
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g +: 1] = 1'b1;
    checkOutput("in_ready", 128'(in_ready), 128'(exp_ready));
    if (reset) begin
      m_lock = 1'b0; m_rr = 0;
      exp_valid = 1'b0; exp_sop = 1'b0; exp_eop = 1'b0; exp_err = 1'b0;
      armed = 1'b1;
    end else if (g >= 0) begin
      exp_err   = m_lock ? in_sop[g +: 1] : !in_sop[g +: 1];
      exp_valid = in_wb[g +: 1];
      exp_sop   = in_wb[g +: 1] & in_sop[g +: 1];
      exp_eop   = in_wb[g +: 1] & in_eop[g +: 1];
      exp_wis   = in_wis[g*W +: W];
      exp_rd    = in_rd[g*R +: R];
      exp_tmask = in_tmask[g*T +: T];
      exp_data  = in_data[g*D +: D];
      if (in_eop[g +: 1] == 1'b1) begin
        m_lock = 1'b0;
        m_rr   = (g + 1) % N;
      end else begin
        m_lock = 1'b1;
        m_id   = g;
      end
    end else begin
      exp_valid = 1'b0; exp_sop = 1'b0; exp_eop = 1'b0; exp_err = 1'b0;
    end
  end

  int           rem[N];
  logic         pkt_wb[N];
  logic [N-1:0] acc;
  logic         first, sop;

  initial begin
    clearInputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_wb_valid", 128'(wb_valid), 128'(1'b0));
    checkOutput("reset_wb_rd", 128'(wb_rd), 128'(0));
    checkOutput("reset_wb_data", 128'(wb_data), 128'(0));
    checkOutput("reset_err_sop", 128'(err_sop), 128'(1'b0));
    reset = 1'b0;

    // Single beat on input 0
    applyStimulus(0, 1, 1, 2'd1, 6'd5, 4'b1011, {32'h44, 32'h33, 32'h22, 32'h11}, 1, 1);
    #1 checkOutput("t1_ready", 128'(in_ready), 128'(4'b0001));
    tick();
    clearInputs();
    checkOutput("t1_valid", 128'(wb_valid), 128'(1'b1));
    checkOutput("t1_wis", 128'(wb_wis), 128'(1));
    checkOutput("t1_rd", 128'(wb_rd), 128'(5));
    checkOutput("t1_tmask", 128'(wb_tmask), 128'(4'b1011));
    checkOutput("t1_data", 128'(wb_data), 128'h00000044_00000033_00000022_00000011);
    checkOutput("t1_sopeop", 128'({wb_sop, wb_eop}), 128'(2'b11));

    // All inputs busy with single-beat packets from reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int p = 0; p < N; p++)
      applyStimulus(p, 1, 1, 2'd0, 6'(10 + p), 4'hf, D'(p), 1, 1);
    #1 checkOutput("t2_ready", 128'(in_ready), 128'(4'b0001));
    for (int c = 0; c < 8; c++) begin
      tick();
      checkOutput("t2_valid", 128'(wb_valid), 128'(1'b1));
      checkOutput("t2_order", 128'(wb_rd), 128'(10 + c % 4));
    end
    clearInputs();

    // Three-beat packet on input 1 blocks input 2
    applyStimulus(2, 1, 1, 2'd0, 6'd20, 4'hf, D'(20), 1, 1);
    applyStimulus(1, 1, 1, 2'd0, 6'd31, 4'hf, D'(31), 1, 0);
    #1 checkOutput("t3_ready_b1", 128'(in_ready), 128'(4'b0010));
    tick();
    applyStimulus(1, 1, 1, 2'd0, 6'd32, 4'hf, D'(32), 0, 0);
    checkOutput("t3_rd_b1", 128'(wb_rd), 128'(31));
    #1 checkOutput("t3_ready_b2", 128'(in_ready), 128'(4'b0010));
    tick();
    applyStimulus(1, 1, 1, 2'd0, 6'd33, 4'hf, D'(33), 0, 1);
    checkOutput("t3_rd_b2", 128'(wb_rd), 128'(32));
    #1 checkOutput("t3_ready_b3", 128'(in_ready), 128'(4'b0010));
    tick();
    applyStimulus(1, 0, 0, 2'd0, 6'd0, 4'h0, D'(0), 0, 0);
    checkOutput("t3_rd_b3", 128'(wb_rd), 128'(33));
    checkOutput("t3_eop", 128'(wb_eop), 128'(1'b1));
    #1 checkOutput("t3_ready_in2", 128'(in_ready), 128'(4'b0100));
    tick();
    clearInputs();
    checkOutput("t3_rd_in2", 128'(wb_rd), 128'(20));

    // Silent (wb=0) two-beat packet on input 3
    applyStimulus(3, 1, 0, 2'd0, 6'd1, 4'hf, D'(1), 1, 0);
    #1 checkOutput("t4_ready_b1", 128'(in_ready), 128'(4'b1000));
    tick();
    applyStimulus(3, 1, 0, 2'd0, 6'd2, 4'hf, D'(2), 0, 1);
    checkOutput("t4_valid_b1", 128'(wb_valid), 128'(1'b0));
    #1 checkOutput("t4_ready_b2", 128'(in_ready), 128'(4'b1000));
    tick();
    clearInputs();
    checkOutput("t4_valid_b2", 128'(wb_valid), 128'(1'b0));
    applyStimulus(0, 1, 1, 2'd0, 6'd0, 4'hf, D'(0), 1, 1);
    applyStimulus(1, 1, 1, 2'd0, 6'd0, 4'hf, D'(0), 1, 1);
    #1 checkOutput("t4_rr_wrap", 128'(in_ready), 128'(4'b0001));
    clearInputs();

    // sop protocol errors
    tick();
    applyStimulus(0, 1, 1, 2'd0, 6'd40, 4'hf, D'(40), 1, 0);
    tick();
    checkOutput("t5_err_ok", 128'(err_sop), 128'(1'b0));
    applyStimulus(0, 1, 1, 2'd0, 6'd41, 4'hf, D'(41), 1, 1);
    #1 checkOutput("t5_ready", 128'(in_ready), 128'(4'b0001));
    tick();
    clearInputs();
    checkOutput("t5_err_locked", 128'(err_sop), 128'(1'b1));
    checkOutput("t5_fwd_rd", 128'(wb_rd), 128'(41));
    tick();
    checkOutput("t5_err_pulse", 128'(err_sop), 128'(1'b0));
    applyStimulus(1, 1, 1, 2'd0, 6'd42, 4'hf, D'(42), 0, 1);
    tick();
    clearInputs();
    checkOutput("t5_err_idle", 128'(err_sop), 128'(1'b1));
    tick();
    checkOutput("t5_err_clear", 128'(err_sop), 128'(1'b0));

    // Reset in the middle of a packet on input 2
    applyStimulus(2, 1, 1, 2'd0, 6'd50, 4'hf, D'(50), 1, 0);
    tick();
    applyStimulus(2, 1, 1, 2'd0, 6'd51, 4'hf, D'(51), 0, 0);
    checkOutput("t6_rd_b1", 128'(wb_rd), 128'(50));
    reset = 1'b1;
    #1 checkOutput("t6_ready_rst", 128'(in_ready), 128'(0));
    tick();
    checkOutput("t6_valid_rst", 128'(wb_valid), 128'(1'b0));
    reset = 1'b0;
    applyStimulus(2, 1, 1, 2'd0, 6'd52, 4'hf, D'(52), 1, 1);
    applyStimulus(0, 1, 1, 2'd0, 6'd53, 4'hf, D'(53), 1, 1);
    #1 checkOutput("t6_ready_after", 128'(in_ready), 128'(4'b0001));
    tick();
    clearInputs();
    checkOutput("t6_rd_after", 128'(wb_rd), 128'(53));
    tick();

    // Randomized packet traffic with occasional sop corruption and resets
    for (int p = 0; p < N; p++) begin
      rem[p] = 0;
      pkt_wb[p] = 1'b0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      acc = in_valid & in_ready;
      @(posedge clk);
      #1;
      if (reset) begin
        reset = 1'b0;
        clearInputs();
        for (int p = 0; p < N; p++) rem[p] = 0;
        acc = '0;
      end else if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1;
      end
      for (int p = 0; p < N; p++) begin
        if (acc[p +: 1] == 1'b1) in_valid[p +: 1] = 1'b0;
        if (in_valid[p +: 1] == 1'b0 && $urandom_range(0, 3) != 0) begin
          first = 1'b0;
          if (rem[p] == 0) begin
            rem[p]    = int'($urandom_range(1, 3));
            pkt_wb[p] = ($urandom_range(0, 3) != 0);
            first     = 1'b1;
          end
          rem[p]--;
          sop = first;
          if ($urandom_range(0, 15) == 0) sop = !sop;
          applyStimulus(p, 1'b1, pkt_wb[p], W'($urandom), R'($urandom), T'($urandom),
                        {$urandom, $urandom, $urandom, $urandom}, sop, rem[p] == 0);
        end
      end
    end
    reset = 1'b0;
    clearInputs();
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
